// File: rtl/logic_issue_unit_if.sv
// Bus bundle between the issue stage, logic_issue_unit and the logic unit:
// command handshake, registered logic-unit drive/return, and result handshake.
interface logic_issue_unit_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_neg;
  logic [3:0]  cmd_select;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] cmd_c;
  logic [31:0] cmd_d;
  logic        cmd_accum;
  logic        cmd_last;

  logic        lu_neg;
  logic [3:0]  lu_select;
  logic [2:0]  lu_op;
  logic [31:0] lu_a;
  logic [31:0] lu_b;
  logic [31:0] lu_c;
  logic [31:0] lu_d;
  logic [31:0] lu_y1;
  logic [31:0] lu_y2;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y1;
  logic [31:0] res_y2;
  logic        res_err;
  logic [7:0]  res_beats;

  modport slave (
    input  cmd_valid, cmd_op, cmd_neg, cmd_select, cmd_a, cmd_b, cmd_c, cmd_d,
    input  cmd_accum, cmd_last, lu_y1, lu_y2, res_ready,
    output cmd_ready, lu_neg, lu_select, lu_op, lu_a, lu_b, lu_c, lu_d,
    output res_valid, res_y1, res_y2, res_err, res_beats
  );

  modport master (
    output cmd_valid, cmd_op, cmd_neg, cmd_select, cmd_a, cmd_b, cmd_c, cmd_d,
    output cmd_accum, cmd_last, lu_y1, lu_y2, res_ready,
    input  cmd_ready, lu_neg, lu_select, lu_op, lu_a, lu_b, lu_c, lu_d,
    input  res_valid, res_y1, res_y2, res_err, res_beats
  );
endinterface

// File: rtl/logic_issue_unit.sv
// Two-stage front end for the ALU logic unit: stage 1 drives the unit, stage 2
// captures Y1/Y2 into a held result, optionally XOR-folding a command burst.
module logic_issue_unit (
  input logic               clk,
  input logic               rst_n,
  logic_issue_unit_if.slave bus
);
  typedef enum logic {ACC_IDLE = 1'b0, ACC_OPEN = 1'b1} acc_state_e;

  logic        s1_valid_q, s1_err_q, s1_accum_q, s1_last_q;
  logic        lu_neg_q;
  logic [3:0]  lu_select_q;
  logic [2:0]  lu_op_q;
  logic [31:0] lu_a_q, lu_b_q, lu_c_q, lu_d_q;

  logic        res_valid_q, res_err_q;
  logic [31:0] res_y1_q, res_y2_q;
  logic [7:0]  res_beats_q;

  acc_state_e  acc_state_q;
  logic [31:0] acc_y1_q, acc_y2_q;
  logic        acc_err_q;
  logic [7:0]  acc_cnt_q;

  logic        op_legal, s2_take, accept, s1_fold, s1_emit;
  logic [31:0] beat_y1, beat_y2, fold_y1_d, fold_y2_d;
  logic        fold_err_d;
  logic [7:0]  fold_cnt_d;

  assign op_legal = bus.cmd_op inside {3'b010, 3'b011, 3'b110, 3'b111};
  assign s2_take  = !res_valid_q || bus.res_ready;
  assign bus.cmd_ready = !s1_valid_q || s2_take;
  assign accept   = bus.cmd_valid && bus.cmd_ready;

  // Non-last burst beats only touch the accumulator, so they never wait on res.
  assign s1_fold  = s1_valid_q && s1_accum_q && !s1_last_q;
  assign s1_emit  = s1_valid_q && !s1_fold && s2_take;

  assign beat_y1    = s1_err_q ? 32'h0 : bus.lu_y1;
  assign beat_y2    = s1_err_q ? 32'h0 : bus.lu_y2;
  assign fold_y1_d  = (acc_state_q == ACC_OPEN) ? (acc_y1_q ^ beat_y1) : beat_y1;
  assign fold_y2_d  = (acc_state_q == ACC_OPEN) ? (acc_y2_q ^ beat_y2) : beat_y2;
  assign fold_err_d = (acc_state_q == ACC_OPEN) ? (acc_err_q | s1_err_q) : s1_err_q;
  assign fold_cnt_d = (acc_cnt_q == 8'hFF) ? 8'hFF : acc_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_accum_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      lu_neg_q    <= 1'b0;
      lu_select_q <= 4'h0;
      lu_op_q     <= 3'h0;
      lu_a_q      <= 32'h0;
      lu_b_q      <= 32'h0;
      lu_c_q      <= 32'h0;
      lu_d_q      <= 32'h0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_y1_q    <= 32'h0;
      res_y2_q    <= 32'h0;
      res_beats_q <= 8'h0;
      acc_state_q <= ACC_IDLE;
      acc_y1_q    <= 32'h0;
      acc_y2_q    <= 32'h0;
      acc_err_q   <= 1'b0;
      acc_cnt_q   <= 8'h0;
    end else begin
      // NOTE: non-blocking updates let stage 2 read the old lu_* while stage 1 reloads them.
      if (accept) begin
        s1_valid_q  <= 1'b1;
        s1_err_q    <= !op_legal;
        s1_accum_q  <= bus.cmd_accum;
        s1_last_q   <= bus.cmd_last;
        lu_neg_q    <= bus.cmd_neg;
        lu_select_q <= op_legal ? bus.cmd_select : 4'h0;
        lu_op_q     <= op_legal ? bus.cmd_op : 3'h0;
        lu_a_q      <= bus.cmd_a;
        lu_b_q      <= bus.cmd_b;
        lu_c_q      <= bus.cmd_c;
        lu_d_q      <= bus.cmd_d;
      end else if (s1_fold || s1_emit) begin
        s1_valid_q  <= 1'b0;
      end

      if (s1_fold) begin
        acc_state_q <= ACC_OPEN;
        acc_y1_q    <= fold_y1_d;
        acc_y2_q    <= fold_y2_d;
        acc_err_q   <= fold_err_d;
        acc_cnt_q   <= fold_cnt_d;
      end

      if (s1_emit) begin
        res_valid_q <= 1'b1;
        if (s1_accum_q) begin
          res_y1_q    <= fold_y1_d;
          res_y2_q    <= fold_y2_d;
          res_err_q   <= fold_err_d;
          res_beats_q <= fold_cnt_d;
          acc_state_q <= ACC_IDLE;
          acc_y1_q    <= 32'h0;
          acc_y2_q    <= 32'h0;
          acc_err_q   <= 1'b0;
          acc_cnt_q   <= 8'h0;
        end else begin
          res_y1_q    <= beat_y1;
          res_y2_q    <= beat_y2;
          res_err_q   <= s1_err_q;
          res_beats_q <= 8'd1;
        end
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.lu_neg    = lu_neg_q;
  assign bus.lu_select = lu_select_q;
  assign bus.lu_op     = lu_op_q;
  assign bus.lu_a      = lu_a_q;
  assign bus.lu_b      = lu_b_q;
  assign bus.lu_c      = lu_c_q;
  assign bus.lu_d      = lu_d_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_y1    = res_y1_q;
  assign bus.res_y2    = res_y2_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_beats = res_beats_q;
endmodule

// File: tb/tb_logic_issue_unit.sv
// Self-checking bench for logic_issue_unit: vector table, directed multi-cycle
// sequences, and random traffic scored against a transaction-level model.
module tb_logic_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic_issue_unit_if bus ();

  logic_issue_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Stand-in logic unit: a simple combinational function of the driven operands.
  assign bus.lu_y1 = bus.lu_a ^ bus.lu_c;
  assign bus.lu_y2 = bus.lu_b ^ bus.lu_d;

  typedef struct packed {
    logic       err;
    logic [7:0] beats;
    logic [31:0] y1;
    logic [31:0] y2;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sel;
    logic        neg;
    logic        accum;
    logic        last;
    logic [31:0] a, b, c, d;
    logic [2:0]  exp_op;
    logic [3:0]  exp_sel;
    logic [31:0] exp_y1, exp_y2;
    logic        exp_err;
    logic [7:0]  exp_beats;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   last_accept;
  res_t exp_q[$];
  logic [31:0] m_y1, m_y2;
  logic m_err;
  int   m_cnt;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [2:0] op);
    return op == 3'b010 || op == 3'b011 || op == 3'b110 || op == 3'b111;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_y1 = '0; m_y2 = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  // Reference: each accepted command becomes either a result or an accumulator update.
  task automatic model_accept();
    res_t r;
    logic [31:0] y1, y2;
    bit e;
    e  = !is_legal(bus.cmd_op);
    y1 = e ? 32'h0 : (bus.cmd_a ^ bus.cmd_c);
    y2 = e ? 32'h0 : (bus.cmd_b ^ bus.cmd_d);
    if (!bus.cmd_accum) begin
      r.err = e; r.beats = 8'd1; r.y1 = y1; r.y2 = y2;
      exp_q.push_back(r);
    end else if (bus.cmd_last) begin
      r.err = m_err | e; r.beats = 8'((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
      r.y1 = m_y1 ^ y1; r.y2 = m_y2 ^ y2;
      exp_q.push_back(r);
      m_y1 = '0; m_y2 = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_y1 ^= y1; m_y2 ^= y2; m_err |= e;
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end
  endtask

  // Called at a negedge after inputs are set; observes, then advances one cycle.
  task automatic tick();
    res_t got;
    #1;
    last_accept = 1'b0;
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        last_accept = 1'b1;
        model_accept();
      end
      if (bus.res_valid) begin
        got.err = bus.res_err; got.beats = bus.res_beats;
        got.y1 = bus.res_y1; got.y2 = bus.res_y2;
        if (exp_q.size() == 0) check("res_unexpected", 96'(bus.res_valid), 96'd0);
        else begin
          check("res_scoreboard", 96'(got), 96'(exp_q[0]));
          if (bus.res_ready) void'(exp_q.pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b0; bus.cmd_neg = 1'b0; bus.cmd_select = 4'h0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0; bus.cmd_d = '0;
    bus.cmd_accum = 1'b0; bus.cmd_last = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] sel, input logic neg,
                       input logic accum, input logic last,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_select = sel; bus.cmd_neg = neg;
    bus.cmd_accum = accum; bus.cmd_last = last;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_c = c; bus.cmd_d = d;
  endtask

  // Hold a command until accepted (bounded), then drop valid.
  task automatic send(input logic [2:0] op, input logic accum, input logic last,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    drive(op, 4'hF, 1'b0, accum, last, a, b, 32'h0, 32'h0);
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = last_accept;
    end
    idle();
    check("send_accept", 96'(ok), 96'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] bp_a[3];
    int idx;

    vecs[0] = '{3'b010, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0, 32'h0,
                3'b010, 4'hF, 32'h0000_00F0, 32'h0000_000F, 1'b0, 8'd1};
    vecs[1] = '{3'b011, 4'h5, 1'b1, 1'b0, 1'b1, 32'h1234_0000, 32'h0, 32'h0000_5678, 32'hFFFF_0000,
                3'b011, 4'h5, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 8'd1};
    vecs[2] = '{3'b110, 4'hA, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'h5555_5555,
                3'b110, 4'hA, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 8'd1};
    vecs[3] = '{3'b111, 4'h3, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'hCAFE_F00D,
                3'b111, 4'h3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 8'd1};
    vecs[4] = '{3'b001, 4'hF, 1'b1, 1'b0, 1'b0, 32'h1, 32'h2, 32'h4, 32'h8,
                3'b000, 4'h0, 32'h0, 32'h0, 1'b1, 8'd1};
    vecs[5] = '{3'b000, 4'h7, 1'b0, 1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 32'h1, 32'h1,
                3'b000, 4'h0, 32'h0, 32'h0, 1'b1, 8'd1};
    vecs[6] = '{3'b101, 4'h9, 1'b0, 1'b0, 1'b0, 32'h55, 32'h66, 32'h0, 32'h0,
                3'b000, 4'h0, 32'h0, 32'h0, 1'b1, 8'd1};
    vecs[7] = '{3'b010, 4'hC, 1'b0, 1'b1, 1'b1, 32'h8, 32'h3, 32'h0, 32'h0,
                3'b010, 4'hC, 32'h8, 32'h3, 1'b0, 8'd1};

    idle();
    bus.res_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_lu_op", 96'(bus.lu_op), 96'd0);
    check("reset_lu_a", 96'(bus.lu_a), 96'd0);
    check("reset_res_valid", 96'(bus.res_valid), 96'd0);
    check("reset_res_y1", 96'(bus.res_y1), 96'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 96'(bus.cmd_ready), 96'd1);
    check("reset_res_beats", 96'(bus.res_beats), 96'd0);

    // Single-beat vector table: one accept, check drive, then check the result.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].neg, vecs[i].accum, vecs[i].last,
            vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      tick();
      idle();
      check($sformatf("vec%0d_lu_op", i), 96'(bus.lu_op), 96'(vecs[i].exp_op));
      check($sformatf("vec%0d_lu_sel", i), 96'(bus.lu_select), 96'(vecs[i].exp_sel));
      check($sformatf("vec%0d_lu_neg", i), 96'(bus.lu_neg), 96'(vecs[i].neg));
      check($sformatf("vec%0d_no_res_yet", i), 96'(bus.res_valid), 96'd0);
      tick();
      check($sformatf("vec%0d_res_valid", i), 96'(bus.res_valid), 96'd1);
      check($sformatf("vec%0d_res", i),
            {23'd0, bus.res_err, bus.res_beats, bus.res_y1, bus.res_y2},
            {23'd0, vecs[i].exp_err, vecs[i].exp_beats, vecs[i].exp_y1, vecs[i].exp_y2});
    end
    tick();

    // Back-to-back: four beats on consecutive cycles, four results in a row.
    for (int i = 0; i < 4; i++) begin
      drive(3'b110, 4'hF, 1'b0, 1'b0, 1'b0, 32'h100 << i, 32'(i), 32'h0, 32'h0);
      #1 check($sformatf("b2b_ready%0d", i), 96'(bus.cmd_ready), 96'd1);
      tick();
      if (i > 0) check($sformatf("b2b_res%0d", i - 1), 96'(bus.res_valid), 96'd1);
    end
    idle();
    tick();
    check("b2b_res3", 96'(bus.res_valid), 96'd1);
    tick();
    check("b2b_drained", 96'(bus.res_valid), 96'd0);

    // Backpressure: three beats offered while res_ready is low for five cycles.
    bp_a = '{32'hA1, 32'hB2, 32'hC3};
    bus.res_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (idx < 3) drive(3'b111, 4'hF, 1'b0, 1'b0, 1'b0, bp_a[idx], 32'h0, 32'h0, 32'h0);
      else idle();
      tick();
      if (last_accept) idx++;
    end
    check("bp_accepted", 96'(idx), 96'd2);
    check("bp_res_held", 96'(bus.res_valid), 96'd1);
    check("bp_ready_low", 96'(bus.cmd_ready), 96'd0);
    check("bp_lu_hold", 96'(bus.lu_a), 96'(bp_a[1]));
    check("bp_res_y1", 96'(bus.res_y1), 96'(bp_a[0]));
    bus.res_ready = 1'b1;
    #1 check("bp_ready_release", 96'(bus.cmd_ready), 96'd1);
    send(3'b111, 1'b0, 1'b0, bp_a[2], 32'h0);
    check("bp_res_y1_next", 96'(bus.res_y1), 96'(bp_a[1]));
    repeat (3) tick();
    check("bp_all_out", 96'(exp_q.size()), 96'd0);

    // Burst fold of three beats.
    send(3'b010, 1'b1, 1'b0, 32'h1, 32'h10);
    check("fold_nores1", 96'(bus.res_valid), 96'd0);
    send(3'b011, 1'b1, 1'b0, 32'h2, 32'h20);
    check("fold_nores2", 96'(bus.res_valid), 96'd0);
    send(3'b110, 1'b1, 1'b1, 32'h4, 32'h40);
    check("fold_nores3", 96'(bus.res_valid), 96'd0);
    tick();
    check("fold_valid", 96'(bus.res_valid), 96'd1);
    check("fold_y1", 96'(bus.res_y1), 96'h7);
    check("fold_beats", 96'(bus.res_beats), 96'd3);
    tick();

    // Illegal op on the last beat of a two-beat burst.
    send(3'b010, 1'b1, 1'b0, 32'h11, 32'h0);
    send(3'b001, 1'b1, 1'b1, 32'h22, 32'h5);
    check("ill_lu_sel", 96'(bus.lu_select), 96'd0);
    tick();
    check("ill_res", {23'd0, bus.res_valid, bus.res_err, bus.res_beats, bus.res_y1},
          {23'd0, 1'b1, 1'b1, 8'd2, 32'h11});
    tick();

    // Non-accum beat in the middle of an open burst.
    send(3'b111, 1'b1, 1'b0, 32'h100, 32'h0);
    send(3'b111, 1'b0, 1'b0, 32'h5A, 32'h0);
    send(3'b111, 1'b1, 1'b1, 32'h200, 32'h0);
    check("mid_single_y1", 96'(bus.res_y1), 96'h5A);
    tick();
    check("mid_burst_res", {bus.res_beats, bus.res_y1}, {8'd2, 32'h300});
    tick();

    // Reset asserted mid-burst clears everything immediately.
    send(3'b010, 1'b1, 1'b0, 32'h3, 32'h0);
    send(3'b010, 1'b1, 1'b0, 32'h5, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {bus.res_valid, bus.res_y1, bus.lu_a, 29'(bus.lu_op)}, 96'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(3'b111, 1'b1, 1'b1, 32'h8, 32'h0);
    tick();
    check("rst_after_res", {bus.res_valid, bus.res_beats, bus.res_y1}, {1'b1, 8'd1, 32'h8});
    tick();

    // Beat counter saturation: 300 beats fold into one result reporting 255.
    for (int i = 0; i < 299; i++) send(3'b011, 1'b1, 1'b0, 32'(i), 32'h0);
    send(3'b011, 1'b1, 1'b1, 32'h0, 32'h0);
    tick();
    check("sat_beats", 96'(bus.res_beats), 96'd255);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 4) == 0) ? 3'($urandom) : {($urandom_range(0, 1) == 1), 1'b1, 1'($urandom)};
      drive(op, 4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            $urandom, $urandom, $urandom, $urandom);
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.res_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    bus.res_ready = 1'b1;
    repeat (6) tick();
    check("drain_empty", 96'(exp_q.size()), 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
